// File: rtl/id_exe_pipe_reg.sv
// ID/EXE pipeline register: captures decoded operands and control for EXE,
// inserts bubbles on hazard/flush, holds on freeze, counts bubble events.
module id_exe_pipe_reg #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             hazard,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      id_val_rn,
  input  logic [31:0]      id_val_rm,
  input  logic [3:0]       id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             id_mem_w_en,
  input  logic             id_b,
  input  logic             id_s,
  input  logic             id_imm,
  input  logic [3:0]       id_exe_cmd,
  input  logic [11:0]      id_shift_operand,
  input  logic [23:0]      id_signed_imm_24,
  input  logic [3:0]       id_sr,
  output logic [31:0]      exe_pc,
  output logic [31:0]      exe_val_rn,
  output logic [31:0]      exe_val_rm,
  output logic [3:0]       exe_dest,
  output logic             exe_wb_en,
  output logic             exe_mem_r_en,
  output logic             exe_mem_w_en,
  output logic             exe_b,
  output logic             exe_s,
  output logic             exe_imm,
  output logic [3:0]       exe_exe_cmd,
  output logic [11:0]      exe_shift_operand,
  output logic [23:0]      exe_signed_imm_24,
  output logic [3:0]       exe_sr,
  output logic             exe_valid,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count
);

  logic [31:0]      r_pc;
  logic [31:0]      r_val_rn;
  logic [31:0]      r_val_rm;
  logic [3:0]       r_dest;
  logic             r_wb_en;
  logic             r_mem_r_en;
  logic             r_mem_w_en;
  logic             r_b;
  logic             r_s;
  logic             r_imm;
  logic [3:0]       r_exe_cmd;
  logic [11:0]      r_shift_operand;
  logic [23:0]      r_signed_imm_24;
  logic [3:0]       r_sr;
  logic             r_valid;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_kill;
  logic w_bub_sat;
  logic w_fl_sat;

  assign w_kill    = flush | hazard;
  assign w_bub_sat = &r_bubble_cnt;
  assign w_fl_sat  = &r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc            <= '0;
      r_val_rn        <= '0;
      r_val_rm        <= '0;
      r_dest          <= '0;
      r_wb_en         <= 1'b0;
      r_mem_r_en      <= 1'b0;
      r_mem_w_en      <= 1'b0;
      r_b             <= 1'b0;
      r_s             <= 1'b0;
      r_imm           <= 1'b0;
      r_exe_cmd       <= '0;
      r_shift_operand <= '0;
      r_signed_imm_24 <= '0;
      r_sr            <= '0;
      r_valid         <= 1'b0;
      r_bubble_cnt    <= '0;
      r_flush_cnt     <= '0;
    end else if (!freeze) begin
      // data fields always follow ID; a bubble only kills control
      r_pc            <= id_pc;
      r_val_rn        <= id_val_rn;
      r_val_rm        <= id_val_rm;
      r_shift_operand <= id_shift_operand;
      r_signed_imm_24 <= id_signed_imm_24;
      r_sr            <= id_sr;
      r_dest          <= w_kill ? 4'h0 : id_dest;
      r_wb_en         <= id_wb_en & ~w_kill;
      r_mem_r_en      <= id_mem_r_en & ~w_kill;
      r_mem_w_en      <= id_mem_w_en & ~w_kill;
      r_b             <= id_b & ~w_kill;
      r_s             <= id_s & ~w_kill;
      r_imm           <= id_imm & ~w_kill;
      r_exe_cmd       <= w_kill ? 4'h0 : id_exe_cmd;
      r_valid         <= ~w_kill;
      if (flush) begin
        if (!w_fl_sat)
          r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end else if (hazard) begin
        if (!w_bub_sat)
          r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end
  end

  assign exe_pc            = r_pc;
  assign exe_val_rn        = r_val_rn;
  assign exe_val_rm        = r_val_rm;
  assign exe_dest          = r_dest;
  assign exe_wb_en         = r_wb_en;
  assign exe_mem_r_en      = r_mem_r_en;
  assign exe_mem_w_en      = r_mem_w_en;
  assign exe_b             = r_b;
  assign exe_s             = r_s;
  assign exe_imm           = r_imm;
  assign exe_exe_cmd       = r_exe_cmd;
  assign exe_shift_operand = r_shift_operand;
  assign exe_signed_imm_24 = r_signed_imm_24;
  assign exe_sr            = r_sr;
  assign exe_valid         = r_valid;
  assign bubble_count      = r_bubble_cnt;
  assign flush_count       = r_flush_cnt;

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Bench for id_exe_pipe_reg: directed table, saturation sequence,
// then random traffic against a stage-level reference model.
module tb_id_exe_pipe_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [3:0]  dest;
    logic        wb;
    logic        mr;
    logic        mw;
    logic        b;
    logic        s;
    logic        imm;
    logic [3:0]  cmd;
    logic [11:0] sh;
    logic [23:0] off;
    logic [3:0]  sr;
    logic        valid;
  } st_t;

  typedef struct {
    logic        rst, frz, fl, hz;
    logic [3:0]  dest;
    logic        wb, mw;
    logic [3:0]  cmd;
    logic [31:0] rn;
    logic        ev, ewb, emw;
    logic [3:0]  edest;
    logic [3:0]  ecmd;
    logic [31:0] ern;
    int          bc, fc;
  } vec_t;

  logic clk = 1'b0;
  logic rst, freeze, flush, hazard;
  st_t  in;
  st_t  act, act2;
  logic [15:0] bcnt, fcnt;
  logic [2:0]  bcnt3, fcnt3;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  id_exe_pipe_reg #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard(hazard),
    .id_pc(in.pc), .id_val_rn(in.rn), .id_val_rm(in.rm),
    .id_dest(in.dest), .id_wb_en(in.wb), .id_mem_r_en(in.mr),
    .id_mem_w_en(in.mw), .id_b(in.b), .id_s(in.s), .id_imm(in.imm),
    .id_exe_cmd(in.cmd), .id_shift_operand(in.sh),
    .id_signed_imm_24(in.off), .id_sr(in.sr),
    .exe_pc(act.pc), .exe_val_rn(act.rn), .exe_val_rm(act.rm),
    .exe_dest(act.dest), .exe_wb_en(act.wb), .exe_mem_r_en(act.mr),
    .exe_mem_w_en(act.mw), .exe_b(act.b), .exe_s(act.s),
    .exe_imm(act.imm), .exe_exe_cmd(act.cmd),
    .exe_shift_operand(act.sh), .exe_signed_imm_24(act.off),
    .exe_sr(act.sr), .exe_valid(act.valid),
    .bubble_count(bcnt), .flush_count(fcnt)
  );

  id_exe_pipe_reg #(.CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard(hazard),
    .id_pc(in.pc), .id_val_rn(in.rn), .id_val_rm(in.rm),
    .id_dest(in.dest), .id_wb_en(in.wb), .id_mem_r_en(in.mr),
    .id_mem_w_en(in.mw), .id_b(in.b), .id_s(in.s), .id_imm(in.imm),
    .id_exe_cmd(in.cmd), .id_shift_operand(in.sh),
    .id_signed_imm_24(in.off), .id_sr(in.sr),
    .exe_pc(act2.pc), .exe_val_rn(act2.rn), .exe_val_rm(act2.rm),
    .exe_dest(act2.dest), .exe_wb_en(act2.wb), .exe_mem_r_en(act2.mr),
    .exe_mem_w_en(act2.mw), .exe_b(act2.b), .exe_s(act2.s),
    .exe_imm(act2.imm), .exe_exe_cmd(act2.cmd),
    .exe_shift_operand(act2.sh), .exe_signed_imm_24(act2.off),
    .exe_sr(act2.sr), .exe_valid(act2.valid),
    .bubble_count(bcnt3), .flush_count(fcnt3)
  );

  // reference model state: what EXE should hold, and raw event counts
  st_t exp;
  int  mb, mf;

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_edge();
    if (rst) begin
      exp = '0;
      mb  = 0;
      mf  = 0;
    end else if (!freeze) begin
      exp = in;
      exp.valid = 1'b1;
      if (flush || hazard) begin
        exp.dest  = 4'h0;
        exp.cmd   = 4'h0;
        exp.wb    = 1'b0;
        exp.mr    = 1'b0;
        exp.mw    = 1'b0;
        exp.b     = 1'b0;
        exp.s     = 1'b0;
        exp.imm   = 1'b0;
        exp.valid = 1'b0;
      end
      if (flush) mf++;
      else if (hazard) mb++;
    end
  endtask

  task automatic chk(input string nm, input logic [150:0] a,
                     input logic [150:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_in();
    in = '0;
    in.pc   = $urandom;
    in.rn   = $urandom;
    in.rm   = $urandom;
    in.dest = 4'($urandom);
    in.wb   = 1'($urandom);
    in.mr   = 1'($urandom);
    in.mw   = 1'($urandom);
    in.b    = 1'($urandom);
    in.s    = 1'($urandom);
    in.imm  = 1'($urandom);
    in.cmd  = 4'($urandom);
    in.sh   = 12'($urandom);
    in.off  = 24'($urandom);
    in.sr   = 4'($urandom);
  endtask

  vec_t tbl[11];

  initial begin
    rst = 1'b0; freeze = 1'b0; flush = 1'b0; hazard = 1'b0;
    in = '0;
    exp = '0; mb = 0; mf = 0;

    //         rst  frz  fl   hz   dest  wb   mw   cmd   rn
    //         ev   ewb  emw  edest ecmd ern  bc fc
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,4'h9,1'b1,1'b1,4'h7,32'h00001234,
                1'b0,1'b0,1'b0,4'h0,4'h0,32'h0,0,0};
    tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,4'h5,1'b1,1'b0,4'h2,32'hDEADBEEF,
                1'b1,1'b1,1'b0,4'h5,4'h2,32'hDEADBEEF,0,0};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b1,4'h6,1'b1,1'b1,4'h3,32'h11111111,
                1'b0,1'b0,1'b0,4'h0,4'h0,32'h11111111,1,0};
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,4'h6,1'b1,1'b1,4'h3,32'h11111111,
                1'b1,1'b1,1'b1,4'h6,4'h3,32'h11111111,1,0};
    tbl[4]  = '{1'b0,1'b0,1'b1,1'b1,4'h7,1'b1,1'b0,4'h4,32'h22222222,
                1'b0,1'b0,1'b0,4'h0,4'h0,32'h22222222,1,1};
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,4'h8,1'b1,1'b1,4'h5,32'h33333333,
                1'b1,1'b1,1'b1,4'h8,4'h5,32'h33333333,1,1};
    tbl[6]  = '{1'b0,1'b1,1'b0,1'b1,4'h9,1'b0,1'b0,4'h6,32'h44444444,
                1'b1,1'b1,1'b1,4'h8,4'h5,32'h33333333,1,1};
    tbl[7]  = '{1'b0,1'b1,1'b1,1'b0,4'hA,1'b1,1'b0,4'h7,32'h55555555,
                1'b1,1'b1,1'b1,4'h8,4'h5,32'h33333333,1,1};
    tbl[8]  = '{1'b0,1'b1,1'b1,1'b1,4'hB,1'b0,1'b1,4'h8,32'h66666666,
                1'b1,1'b1,1'b1,4'h8,4'h5,32'h33333333,1,1};
    tbl[9]  = '{1'b0,1'b0,1'b1,1'b0,4'hC,1'b1,1'b1,4'h9,32'h77777777,
                1'b0,1'b0,1'b0,4'h0,4'h0,32'h77777777,1,2};
    tbl[10] = '{1'b1,1'b1,1'b1,1'b1,4'hD,1'b1,1'b1,4'hA,32'h88888888,
                1'b0,1'b0,1'b0,4'h0,4'h0,32'h0,0,0};

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst; freeze = tbl[i].frz;
      flush = tbl[i].fl; hazard = tbl[i].hz;
      in = '0;
      in.pc = 32'h1000 + 32'(i);
      in.dest = tbl[i].dest; in.wb = tbl[i].wb;
      in.mw = tbl[i].mw; in.cmd = tbl[i].cmd; in.rn = tbl[i].rn;
      tick();
      chk($sformatf("vec%0d_ctl", i),
          151'({act.valid, act.wb, act.mw, act.dest, act.cmd}),
          151'({tbl[i].ev, tbl[i].ewb, tbl[i].emw, tbl[i].edest,
                tbl[i].ecmd}));
      chk($sformatf("vec%0d_rn", i), 151'(act.rn), 151'(tbl[i].ern));
      chk($sformatf("vec%0d_cnt", i), 151'({bcnt, fcnt}),
          151'({16'(tbl[i].bc), 16'(tbl[i].fc)}));
    end

    // saturation: ten hazards in a row, narrow counter sticks at 7
    rst = 1'b0; freeze = 1'b0; flush = 1'b0; hazard = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_in();
      tick();
    end
    chk("sat_bubble3", 151'(bcnt3), 151'(3'd7));
    chk("sat_bubble16", 151'(bcnt), 151'(16'd10));
    chk("sat_flush3", 151'(fcnt3), 151'(3'd0));
    hazard = 1'b0;

    // random traffic; model started from a clean reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 500; i++) begin
      rand_in();
      rst    = ($urandom_range(0, 63) == 0);
      freeze = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 5) == 0);
      hazard = ($urandom_range(0, 2) == 0);
      tick();
      chk("rnd_regs", 151'(act), 151'(exp));
      chk("rnd_cnt16", 151'({bcnt, fcnt}),
          151'({16'(sat(mb, 65535)), 16'(sat(mf, 65535))}));
      chk("rnd_cnt3", 151'({bcnt3, fcnt3}),
          151'({3'(sat(mb, 7)), 3'(sat(mf, 7))}));
      if (!act.valid)
        chk("rnd_bubble_safe", 151'({act.wb, act.mw}), 151'(2'b00));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_exe_pipe_reg.md
# id_exe_pipe_reg

ID/EXE pipeline register of the 5-stage core, between the decode stage and the execute stage. Captures decoded operands and control each cycle and drives the EXE-stage destination/write-enable that the hazard detection logic compares against. Inserts a bubble when a data hazard is flagged or a taken branch flushes the pipe, and holds everything on a global freeze. Saturating counters record bubbles and flushes for performance debug.

## Interface
- CNT_W, 16, width of each saturating event counter

- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- freeze  in  1  global stall (memory wait); hold all state
- flush  in  1  taken branch resolved in EXE; kill the instruction entering EXE
- hazard  in  1  data hazard from hazard detection; insert bubble
- id_pc  in  32  PC+4 of decoded instruction
- id_val_rn, id_val_rm  in  32 each  register-file read values
- id_dest  in  4  destination register
- id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm  in  1 each  decoded control bits
- id_exe_cmd  in  4  ALU command
- id_shift_operand  in  12  shifter operand field
- id_signed_imm_24  in  24  branch offset
- id_sr  in  4  status flags NZCV at decode
- exe_pc, exe_val_rn, exe_val_rm  out  32 each  registered copies
- exe_dest  out  4  EXE destination (to hazard detection)
- exe_wb_en  out  1  EXE write-back enable (to hazard detection)
- exe_mem_r_en, exe_mem_w_en, exe_b, exe_s, exe_imm  out  1 each
- exe_exe_cmd  out  4
- exe_shift_operand  out  12
- exe_signed_imm_24  out  24
- exe_sr  out  4
- exe_valid  out  1  register holds a real instruction (not bubble)
- bubble_count  out  CNT_W  hazard bubbles inserted
- flush_count  out  CNT_W  flushes applied

## Operation
- Per-edge action, strict priority: rst > freeze > flush > hazard > load.
- rst: every output register to 0, including exe_valid and both counters.
- freeze: all registers and counters hold; flush/hazard ignored that cycle (branch unit keeps flush asserted until freeze drops).
- flush: bubble — exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s, exe_imm, exe_valid, exe_exe_cmd, exe_dest cleared to 0; data fields (pc, val_rn, val_rm, shift_operand, signed_imm_24, sr) loaded from id_* (don't-care downstream). flush_count increments.
- hazard (no flush): same bubble as flush; bubble_count increments.
- flush and hazard together: flush wins; only flush_count increments.
- load: all exe_* from corresponding id_*; exe_valid = 1.
- Counters saturate at 2^CNT_W-1; no wrap.
- Bubble guarantee: exe_wb_en = 0 and exe_mem_w_en = 0 whenever exe_valid = 0, so no architectural side effect leaks from a bubble.
- No combinational path from any input to any output.

## Timing
- Latency 1 cycle: id_* sampled at edge N appear on exe_* after edge N.
- exe_dest/exe_wb_en valid from the clock edge; hazard detection uses them combinationally in the same cycle the next instruction sits in ID.
- Hazard asserted in cycle N -> bubble visible in cycle N+1; the stalled ID instruction (held upstream) loads at the first edge where hazard = 0.
- freeze held for k cycles -> outputs unchanged for k cycles, then normal priority resumes.
- rst mid-stream: outputs 0 after the next edge regardless of other inputs.

## Test plan
- Reset: drive id_* nonzero, rst=1 one edge -> all exe_* = 0, exe_valid=0, both counters 0.
- Normal load: id_dest=4'h5, id_wb_en=1, id_exe_cmd=4'h2, id_val_rn=32'hDEADBEEF -> next cycle exe_dest=5, exe_wb_en=1, exe_exe_cmd=2, exe_val_rn=DEADBEEF, exe_valid=1.
- Hazard: hazard=1 with id_wb_en=1, id_mem_w_en=1 -> exe_wb_en=0, exe_mem_w_en=0, exe_dest=0, exe_valid=0, bubble_count=1; hazard=0 next -> instruction loads.
- Flush vs hazard: flush=1, hazard=1 same cycle -> bubble, flush_count=1, bubble_count unchanged.
- Freeze: load instruction, then freeze=1 for 3 cycles with hazard=1 and changing id_* -> exe_* and counters constant all 3 cycles.
- Saturation: CNT_W=3, hazard=1 for 10 cycles -> bubble_count stops at 7.
